fft_out_serializer: RTL and testbench

Drain block at the back end of the 32-point FFT pipeline. Captures the 32 parallel results of the final butterfly stage as one frame and emits them one word per handshake on a valid/ready stream, with an index and end-of-frame flag. A two-frame ping-pong store lets the next frame be captured while the current one drains, so a stalled consumer backpressures the FFT only when both slots are full.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_frame_buf.sv | 29 ++
 rtl/fft_out_serializer.sv | 120 ++++++++++++
 tb/tb_fft_out_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, slot-occupancy encoding and the
// 5-bit bit-reverse used by the butterfly stages and the output serializer.
package fft_pkg;

  localparam int FFT_POINTS = 32;
  localparam int FFT_LOG2   = 5;

  typedef logic [FFT_LOG2-1:0] fft_idx_t;

  // Number of ping-pong slots currently holding an undrained frame.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } fft_occ_e;

  function automatic fft_idx_t fft_bitrev(input fft_idx_t idx);
    fft_idx_t r;
    for (int b = 0; b < FFT_LOG2; b++) begin
      r[b] = idx[FFT_LOG2-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One frame slot: all POINTS words written in a single cycle, one word read
// by index. The read is combinational; the consumer registers it.
module fft_frame_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int POINTS = FFT_POINTS,
  parameter int IDX_W  = FFT_LOG2
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [POINTS*DATA_W-1:0] frame_i,
  input  logic [IDX_W-1:0]         rd_idx_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [POINTS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int s = 0; s < POINTS; s++) begin
        mem_q[s] <= frame_i[s*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fft_out_serializer.sv
// Two-slot ping-pong frame store draining one FFT word per valid/ready beat.
// Define FFT_OUT_BITREV_EN to read slots in bit-reversed order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int p_dataBits = 16,
  parameter int p_points   = FFT_POINTS,
  parameter int p_idxBits  = FFT_LOG2
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [p_points*p_dataBits-1:0] i_frame,
  input  logic                           i_frameValid,
  output logic                           o_frameReady,
  output logic [p_dataBits-1:0]          o_data,
  output logic [p_idxBits-1:0]           o_index,
  output logic                           o_last,
  output logic                           o_valid,
  input  logic                           i_ready
);

  localparam logic [p_idxBits-1:0] LAST_IDX = p_idxBits'(p_points - 1);

  fft_occ_e               cnt_q, cnt_d;
  logic                   wp_q, wp_d;
  logic                   rp_q, rp_d;
  logic [p_idxBits-1:0]   k_q, k_d;
  logic                   o_valid_q;
  logic [p_dataBits-1:0]  o_data_q;
  logic [p_idxBits-1:0]   o_index_q;
  logic                   o_last_q;

  logic                   cap;
  logic                   rel_word;
  logic                   rel_frame;
  logic [p_idxBits-1:0]   sel_d;
  logic [p_dataBits-1:0]  word_d;
  logic [1:0]             slot_we;
  logic [p_dataBits-1:0]  slot_rd [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign slot_we[gi] = cap && (wp_q == 1'(gi));

      fft_frame_buf #(
        .DATA_W (p_dataBits),
        .POINTS (p_points),
        .IDX_W  (p_idxBits)
      ) u_buf (
        .clk       (CLK),
        .we_i      (slot_we[gi]),
        .frame_i   (i_frame),
        .rd_idx_i  (sel_d),
        .rd_data_o (slot_rd[gi])
      );
    end
  endgenerate

`ifdef FFT_OUT_BITREV_EN
  assign sel_d = fft_bitrev(k_d);
`else
  assign sel_d = k_d;
`endif

  always_comb begin
    cap       = i_frameValid && (cnt_q != OCC_FULL);
    rel_word  = o_valid_q && i_ready;
    rel_frame = rel_word && (k_q == LAST_IDX);

    cnt_d = cnt_q;
    unique case ({cap, rel_frame})
      2'b10:   cnt_d = (cnt_q == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   cnt_d = (cnt_q == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: cnt_d = cnt_q;
    endcase

    wp_d = wp_q ^ cap;
    rp_d = rp_q ^ rel_frame;
    // k wraps 31 -> 0 on its own because p_points is a power of two.
    k_d  = rel_word ? k_q + 1'b1 : k_q;

    // The slot being read next may be the one written on this same edge
    // (empty store, or capture coinciding with the last-word release);
    // take that word straight from the input so there is no bubble.
    if (cap && (wp_q == rp_d)) begin
      word_d = i_frame[sel_d*p_dataBits +: p_dataBits];
    end else begin
      word_d = slot_rd[rp_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= OCC_EMPTY;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      k_q       <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_index_q <= '0;
      o_last_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      k_q       <= k_d;
      o_valid_q <= (cnt_d != OCC_EMPTY);
      o_data_q  <= (cnt_d != OCC_EMPTY) ? word_d : '0;
      o_index_q <= k_d;
      o_last_q  <= (cnt_d != OCC_EMPTY) && (k_d == LAST_IDX);
    end
  end

  assign o_frameReady = (cnt_q != OCC_FULL);
  assign o_valid      = o_valid_q;
  assign o_data       = o_data_q;
  assign o_index      = o_index_q;
  assign o_last       = o_last_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed-random bench: frames are modelled as queues of expected words and
// every cycle's outputs are compared against that model.
module tb_fft_out_serializer;

  logic         CLK;
  logic         RST;
  logic [511:0] i_frame;
  logic         i_frameValid;
  logic         o_frameReady;
  logic [15:0]  o_data;
  logic [4:0]   o_index;
  logic         o_last;
  logic         o_valid;
  logic         i_ready;

  fft_out_serializer dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_frame      (i_frame),
    .i_frameValid (i_frameValid),
    .o_frameReady (o_frameReady),
    .o_data       (o_data),
    .o_index      (o_index),
    .o_last       (o_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] d;
    int          idx;
  } word_t;

  word_t q[$];
  int    held;
  int    total;
  int    bad;
  bit    chk_en;
  bit    accepted;
  int    budget;

  function automatic int sel_of(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) begin
      r = r | (((k >> b) & 1) << (4 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // One clock: compare outputs against the model, apply this edge's handshakes.
  task automatic tick();
    bit rdy;
    @(negedge CLK);
    rdy = (held < 2);
    if (chk_en) begin
      chk("frame_ready", 32'(o_frameReady), 32'(rdy));
      chk("valid", 32'(o_valid), 32'(held != 0));
      if (held != 0 && q.size() > 0) begin
        chk("data", 32'(o_data), 32'(q[0].d));
        chk("index", 32'(o_index), q[0].idx);
        chk("last", 32'(o_last), 32'(q[0].idx == 31));
      end
    end
    accepted = 1'b0;
    if (RST) begin
      q.delete();
      held = 0;
    end else begin
      if (held != 0 && i_ready && q.size() > 0) begin
        word_t w;
        w = q.pop_front();
        $display("word idx=%0d data=%h", w.idx, w.d);
        if (w.idx == 31) held--;
      end
      if (i_frameValid && rdy) begin
        for (int k = 0; k < 32; k++) begin
          word_t w;
          w.d   = i_frame[sel_of(k)*16 +: 16];
          w.idx = k;
          q.push_back(w);
        end
        held++;
        accepted = 1'b1;
        $display("frame accepted, frames held=%0d", held);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_frame();
    for (int s = 0; s < 32; s++) i_frame[s*16 +: 16] = 16'($urandom);
  endtask

  // mode 0: ready held high, 1: toggling, 2: random
  task automatic drain(input int mode);
    int n;
    n = 0;
    while (held != 0 && n < 2000) begin
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (n % 2 == 0);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    if (held != 0) timeout("drain");
  endtask

  initial begin
    RST          = 1'b1;
    i_frame      = '0;
    i_frameValid = 1'b0;
    i_ready      = 1'b0;
    held         = 0;
    total        = 0;
    bad          = 0;
    chk_en       = 1'b0;
    tick();
    tick();
    RST    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_index", 32'(o_index), 32'd0);
    chk("rst_last", 32'(o_last), 32'd0);
    chk("rst_frame_ready", 32'(o_frameReady), 32'd1);

    // Single frame s+100, latency and ordering
    for (int s = 0; s < 32; s++) i_frame[s*16 +: 16] = 16'(s + 100);
    i_frameValid = 1'b1;
    i_ready      = 1'b1;
    tick();
    i_frameValid = 1'b0;
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("lat_index", 32'(o_index), 32'd0);
    chk("lat_data", 32'(o_data), 32'd100);
    tick();
    chk("idx1_index", 32'(o_index), 32'd1);
`ifdef FFT_OUT_BITREV_EN
    chk("idx1_data", 32'(o_data), 32'd116);
`else
    chk("idx1_data", 32'(o_data), 32'd101);
`endif
    for (int i = 0; i < 31; i++) tick();
    chk("drained_valid", 32'(o_valid), 32'd0);

    // Three frames offered with consumer stalled
    i_ready = 1'b0;
    rand_frame();
    i_frameValid = 1'b1;
    tick();
    rand_frame();
    tick();
    rand_frame();
    chk("full_frame_ready", 32'(o_frameReady), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    i_ready = 1'b1;
    budget  = 0;
    while (!accepted && budget < 200) begin
      tick();
      budget++;
    end
    if (!accepted) timeout("third_frame_accept");
    i_frameValid = 1'b0;
    drain(1);

    // Capture coinciding with final-word release at one frame held
    rand_frame();
    i_frameValid = 1'b1;
    i_ready      = 1'b1;
    tick();
    i_frameValid = 1'b0;
    budget = 0;
    while (q.size() > 0 && q[0].idx != 31 && budget < 100) begin
      tick();
      budget++;
    end
    if (q.size() == 0 || q[0].idx != 31) timeout("reach_idx31");
    rand_frame();
    i_frameValid = 1'b1;
    tick();
    i_frameValid = 1'b0;
    chk("sim_accept", 32'(accepted), 32'd1);
    chk("sim_valid", 32'(o_valid), 32'd1);
    chk("sim_index", 32'(o_index), 32'd0);
    chk("sim_frame_ready", 32'(o_frameReady), 32'd1);
    drain(2);

    // Reset mid-frame with a second frame queued
    rand_frame();
    i_frameValid = 1'b1;
    i_ready      = 1'b1;
    tick();
    rand_frame();
    tick();
    i_frameValid = 1'b0;
    budget = 0;
    while (q.size() > 0 && q[0].idx != 10 && budget < 100) begin
      tick();
      budget++;
    end
    if (q.size() == 0 || q[0].idx != 10) timeout("reach_idx10");
    chk("pre_rst_index", 32'(o_index), 32'd10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("post_rst_valid", 32'(o_valid), 32'd0);
    chk("post_rst_frame_ready", 32'(o_frameReady), 32'd1);
    rand_frame();
    i_frameValid = 1'b1;
    tick();
    i_frameValid = 1'b0;
    chk("restart_valid", 32'(o_valid), 32'd1);
    chk("restart_index", 32'(o_index), 32'd0);
    drain(2);

    // Extreme signed values pass bit-exact
    for (int s = 0; s < 32; s++) i_frame[s*16 +: 16] = (s % 2 == 0) ? 16'h7FFF : 16'h8000;
    i_frameValid = 1'b1;
    tick();
    i_frameValid = 1'b0;
    chk("extreme_word0", 32'(o_data), 32'h7FFF);
    drain(0);
    chk("end_valid", 32'(o_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
